// File: rtl/alu_op_seq_pkg.sv
// Shared types and constants for the alu_op_seq sequencer.
// Optional accumulator operand is enabled by defining ALU_OP_SEQ_ACC_EN.
package alu_op_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } alu_seq_state_e;

  // Bit positions inside out_flags.
  localparam int FLG_OVF   = 2;
  localparam int FLG_ZERO  = 1;
  localparam int FLG_CARRY = 0;

  function automatic logic [2:0] pack_flags(input logic ovf, input logic zero, input logic carry);
    logic [2:0] f;
    f            = '0;
    f[FLG_OVF]   = ovf;
    f[FLG_ZERO]  = zero;
    f[FLG_CARRY] = carry;
    return f;
  endfunction

endpackage

// File: rtl/alu_seq_sat_cnt.sv
// Saturating up-counter: counts inc pulses, sticks at all-ones.
module alu_seq_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/alu_op_seq.sv
// Three-state sequencer driving an external 4-bit add/sub unit and holding its result.
// Define ALU_OP_SEQ_ACC_EN to add a result accumulator usable as operand a.
module alu_op_seq
  import alu_op_seq_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid-side payload is only looked at when ready is high.
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sub,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic             in_acc,
  output logic             alu_sub,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  input  logic [3:0]       alu_result,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  input  logic             alu_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_result,
  output logic [2:0]       out_flags,
  output logic [CNT_W-1:0] ops_done,
  output alu_seq_state_e   dbg_state
);

  alu_seq_state_e state_q, state_d;
  logic           alu_sub_q, alu_sub_d;
  logic [3:0]     alu_a_q, alu_a_d;
  logic [3:0]     alu_b_q, alu_b_d;
  logic [3:0]     out_result_q, out_result_d;
  logic [2:0]     out_flags_q, out_flags_d;
  logic           out_fire;
  logic [3:0]     op_a;

`ifdef ALU_OP_SEQ_ACC_EN
  logic [3:0] acc_q, acc_d;

  assign op_a  = in_acc ? acc_q : in_a;
  assign acc_d = out_fire ? out_result_q : acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
`else
  logic unused_in_acc;

  assign op_a          = in_a;
  assign unused_in_acc = in_acc;
`endif

  always_comb begin
    state_d      = state_q;
    alu_sub_d    = alu_sub_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    out_result_d = out_result_q;
    out_flags_d  = out_flags_q;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_fire     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          alu_sub_d = in_sub;
          alu_a_d   = op_a;
          alu_b_d   = in_b;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        // The add/sub unit has had a full cycle to settle on the registered operands.
        out_result_d = alu_result;
        out_flags_d  = pack_flags(alu_overflow, alu_zero, alu_carry);
        state_d      = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          out_fire = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      alu_sub_q    <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      out_result_q <= '0;
      out_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      alu_sub_q    <= alu_sub_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      out_result_q <= out_result_d;
      out_flags_q  <= out_flags_d;
    end
  end

  alu_seq_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_ops_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (out_fire),
    .count(ops_done)
  );

  assign alu_sub    = alu_sub_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_op_seq.sv
// Bench for alu_op_seq: a default-width instance and a CNT_W=2 instance share one stimulus stream.
module tb_alu_op_seq;
  import alu_op_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0, in_sub = 1'b0, in_acc = 1'b0, out_ready = 1'b0;
  logic [3:0] in_a = '0, in_b = '0;

  logic           a_in_ready, a_alu_sub, a_out_valid, a_ovf, a_zero, a_carry;
  logic [3:0]     a_alu_a, a_alu_b, a_alu_result, a_out_result;
  logic [2:0]     a_out_flags;
  logic [7:0]     a_ops;
  alu_seq_state_e a_state;

  logic           b_in_ready, b_alu_sub, b_out_valid, b_ovf, b_zero, b_carry;
  logic [3:0]     b_alu_a, b_alu_b, b_alu_result, b_out_result;
  logic [2:0]     b_out_flags;
  logic [1:0]     b_ops;
  alu_seq_state_e b_state;

  // Plain-arithmetic add/sub: returns {overflow, zero, carry, result[3:0]}.
  function automatic logic [6:0] alu_fn(input logic sub, input logic [3:0] a, input logic [3:0] b);
    int ua, ub, ur, sa, sb, sr;
    logic [3:0] res;
    logic c, v;
    ua  = int'(a);
    ub  = int'(b);
    sa  = (ua >= 8) ? ua - 16 : ua;
    sb  = (ub >= 8) ? ub - 16 : ub;
    ur  = sub ? ua - ub : ua + ub;
    sr  = sub ? sa - sb : sa + sb;
    res = 4'(ur & 15);
    c   = sub ? (ua >= ub) : (ur > 15);
    v   = (sr > 7) || (sr < -8);
    return {v, (res == 4'd0), c, res};
  endfunction

  assign {a_ovf, a_zero, a_carry, a_alu_result} = alu_fn(a_alu_sub, a_alu_a, a_alu_b);
  assign {b_ovf, b_zero, b_carry, b_alu_result} = alu_fn(b_alu_sub, b_alu_a, b_alu_b);

  alu_op_seq #(.CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_sub(in_sub), .in_a(in_a), .in_b(in_b), .in_acc(in_acc),
    .alu_sub(a_alu_sub), .alu_a(a_alu_a), .alu_b(a_alu_b),
    .alu_result(a_alu_result), .alu_overflow(a_ovf), .alu_zero(a_zero), .alu_carry(a_carry),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_result(a_out_result), .out_flags(a_out_flags),
    .ops_done(a_ops), .dbg_state(a_state)
  );

  alu_op_seq #(.CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_sub(in_sub), .in_a(in_a), .in_b(in_b), .in_acc(in_acc),
    .alu_sub(b_alu_sub), .alu_a(b_alu_a), .alu_b(b_alu_b),
    .alu_result(b_alu_result), .alu_overflow(b_ovf), .alu_zero(b_zero), .alu_carry(b_carry),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_result(b_out_result), .out_flags(b_out_flags),
    .ops_done(b_ops), .dbg_state(b_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference state: completed handshakes and last delivered result.
  int         ops_m = 0;
  logic [3:0] acc_m = '0;

  function automatic logic [3:0] eff_a(input logic [3:0] a, input logic acc);
    logic [3:0] r;
    r = a;
`ifdef ALU_OP_SEQ_ACC_EN
    if (acc) r = acc_m;
`endif
    return r;
  endfunction

  // Starts and ends on a falling edge; one full op, optional stall in DONE,
  // optional junk on the input side while the block is busy.
  task automatic do_op(input logic sub, input logic [3:0] a, input logic [3:0] b, input logic acc,
                       input int stall, input logic junk, input logic [6:0] exp);
    logic [3:0] ea;
    ea = eff_a(a, acc);
    check("idle_ready", {a_in_ready, a_out_valid}, 2'b10);
    in_valid = 1'b1; in_sub = sub; in_a = a; in_b = b; in_acc = acc; out_ready = 1'b0;
    @(negedge clk);
    check("exec_state", int'(a_state), int'(EXEC));
    check("exec_hs", {a_in_ready, a_out_valid}, 2'b00);
    check("alu_drive", {a_alu_sub, a_alu_a, a_alu_b}, {sub, ea, b});
    in_valid = junk;
    if (junk) {in_sub, in_a, in_b, in_acc} = 10'($urandom);
    @(negedge clk);
    check("done_hs", {a_in_ready, a_out_valid}, 2'b01);
    check("result", a_out_result, exp[3:0]);
    check("flags", a_out_flags, exp[6:4]);
    check("result_w2", {b_out_flags, b_out_result}, exp);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("hold", {a_out_valid, a_in_ready, a_out_flags, a_out_result, a_alu_sub, a_alu_a, a_alu_b},
            {2'b10, exp, sub, ea, b});
    end
    out_ready = 1'b1;
    @(negedge clk);
    ops_m++;
`ifdef ALU_OP_SEQ_ACC_EN
    acc_m = exp[3:0];
`endif
    check("back_idle", {a_in_ready, a_out_valid}, 2'b10);
    check("ops_done", a_ops, (ops_m > 255) ? 255 : ops_m);
    check("ops_done_sat", b_ops, (ops_m > 3) ? 3 : ops_m);
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  typedef struct {
    logic       sub;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] res;
    logic [2:0] flg;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic       s, k, j;
    logic [3:0] ra, rb;
    logic [6:0] e;

    vecs[0] = '{1'b0, 4'd3,  4'd5, 4'd8,  3'b100};
    vecs[1] = '{1'b1, 4'd5,  4'd5, 4'd0,  3'b011};
    vecs[2] = '{1'b0, 4'd15, 4'd1, 4'd0,  3'b011};
    vecs[3] = '{1'b0, 4'd7,  4'd1, 4'd8,  3'b100};
    vecs[4] = '{1'b1, 4'd0,  4'd1, 4'd15, 3'b000};
    vecs[5] = '{1'b1, 4'd8,  4'd1, 4'd7,  3'b101};
    vecs[6] = '{1'b0, 4'd0,  4'd0, 4'd0,  3'b010};
    vecs[7] = '{1'b1, 4'd2,  4'd3, 4'd15, 3'b000};

    #12;
    check("rst_state", int'(a_state), int'(IDLE));
    check("rst_hs", {a_in_ready, a_out_valid}, 2'b10);
    check("rst_regs", {a_alu_sub, a_alu_a, a_alu_b, a_out_result, a_out_flags}, 0);
    check("rst_ops", {a_ops, b_ops}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset landing in EXEC drops the operation.
    in_valid = 1'b1; in_sub = 1'b0; in_a = 4'd3; in_b = 4'd5;
    @(negedge clk);
    check("pre_abort_state", int'(a_state), int'(EXEC));
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("abort_state", int'(a_state), int'(IDLE));
    check("abort_hs", {a_in_ready, a_out_valid}, 2'b10);
    check("abort_alu", {a_alu_a, a_alu_b}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ops", {a_ops, b_ops}, 0);
    check("abort_novalid", a_out_valid, 0);

    // Directed vectors back to back; first five exercise the 2-bit counter saturating.
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].sub, vecs[i].a, vecs[i].b, 1'b0, 0, 1'b0, {vecs[i].flg, vecs[i].res});
    end

    // Backpressure with junk requests offered during the stall.
    do_op(1'b0, 4'd7, 4'd1, 1'b0, 5, 1'b1, 7'b100_1000);

    // Accumulator chain: 2+3, then acc-selected a minus 1.
    do_op(1'b0, 4'd2, 4'd3, 1'b0, 0, 1'b0, 7'b000_0101);
`ifdef ALU_OP_SEQ_ACC_EN
    do_op(1'b1, 4'd2, 4'd1, 1'b1, 0, 1'b0, 7'b001_0100);
`else
    do_op(1'b1, 4'd2, 4'd1, 1'b1, 0, 1'b0, 7'b001_0001);
`endif

    for (int i = 0; i < 40; i++) begin
      s  = 1'($urandom_range(0, 1));
      k  = 1'($urandom_range(0, 1));
      j  = 1'($urandom_range(0, 1));
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      e  = alu_fn(s, eff_a(ra, k), rb);
      do_op(s, ra, rb, k, int'($urandom_range(0, 3)), j, e);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
